// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_ctrl_fsm_pkg: opcodes, state and control-field encodings for the multicycle RV32I controller
package cpu_ctrl_fsm_pkg;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;
  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;
  localparam logic [6:0] OP_L = 7'h03;
  localparam logic [6:0] OP_S = 7'h23;
  localparam logic [6:0] OP_B = 7'h63;
  localparam logic [6:0] OP_J = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [6:0] OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;
  localparam logic [6:0] OP_SYS = 7'h73;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JALR = 2'd2;
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;
  localparam logic [1:0] FAULT_NONE = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_SYS = 2'd3;
  function automatic logic op_legal(input logic [6:0] op);
    return op inside {OP_R, OP_I, OP_L, OP_S, OP_B, OP_J, OP_JALR, OP_LUI, OP_AUIPC};
  endfunction
endpackage

// File: rtl/cpu_ctrl_fsm_mem_wait_timer.sv
// cpu_ctrl_fsm_mem_wait_timer: counts consecutive not-ready wait cycles, flags expiry on the last allowed one
module cpu_ctrl_fsm_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic expire
);
  localparam int TW = MEM_TIMEOUT > 1 ? $clog2(MEM_TIMEOUT) : 1;
  logic [TW-1:0] timer;
  assign expire = en && timer == TW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk)
    if (rst || !en || expire) timer <= '0;
    else timer <= timer + TW'(1);
endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multicycle fetch/decode/exec/mem/wb controller with memory timeout, halt and retire count
import cpu_ctrl_fsm_pkg::*;
module cpu_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic [31:0] inst,
  input  logic imem_ready,
  input  logic dmem_ready,
  input  logic branch_taken,
  output logic imem_req,
  output logic ir_write,
  output logic pc_write,
  output logic [1:0] pc_src,
  output logic reg_write,
  output logic [1:0] wb_sel,
  output logic mem_read,
  output logic mem_write,
  output logic halt,
  output logic [1:0] fault_code,
  output logic [CNT_W-1:0] instret
);
  state_t state, state_n;
  logic [1:0] fault_n;
  logic [6:0] op;
  logic ready, waiting, expire, retire;
  logic unused_inst;
  assign op = inst[6:0];
  assign unused_inst = ^inst[31:7];
  assign ready = state == S_FETCH ? imem_ready : dmem_ready;
  assign waiting = (state == S_FETCH || state == S_MEM) && !ready;
  cpu_ctrl_fsm_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk(clk), .rst(rst), .en(waiting), .expire(expire)
  );
  always_comb begin
    state_n = state;
    fault_n = fault_code;
    retire = 1'b0;
    imem_req = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_PLUS4;
    reg_write = 1'b0;
    wb_sel = WB_ALU;
    mem_read = 1'b0;
    mem_write = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
        state_n = imem_ready ? S_DECODE : expire ? S_HALT : S_FETCH;
        fault_n = !imem_ready && expire ? FAULT_TIMEOUT : fault_code;
      end
      S_DECODE: begin
        state_n = op_legal(op) ? S_EXEC : S_HALT;
        fault_n = op == OP_SYS ? FAULT_SYS : op_legal(op) ? fault_code : FAULT_ILLEGAL;
      end
      S_EXEC: begin
        pc_write = op == OP_B;
        pc_src = op == OP_B && branch_taken ? PC_BRANCH : PC_PLUS4;
        retire = op == OP_B;
        state_n = op == OP_B ? S_FETCH : (op == OP_L || op == OP_S) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_read = op == OP_L;
        mem_write = op == OP_S;
        pc_write = dmem_ready && op == OP_S;
        retire = dmem_ready && op == OP_S;
        state_n = dmem_ready ? (op == OP_S ? S_FETCH : S_WB) : expire ? S_HALT : S_MEM;
        fault_n = !dmem_ready && expire ? FAULT_TIMEOUT : fault_code;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel = op == OP_L ? WB_LOAD : (op == OP_J || op == OP_JALR) ? WB_PC4 : op == OP_LUI ? WB_IMM : WB_ALU;
        pc_write = 1'b1;
        pc_src = op == OP_J ? PC_BRANCH : op == OP_JALR ? PC_JALR : PC_PLUS4;
        retire = 1'b1;
        state_n = S_FETCH;
      end
      S_HALT: state_n = S_HALT;
      default: state_n = S_FETCH;
    endcase
    if (rst) begin
      imem_req = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg_write = 1'b0;
      mem_read = 1'b0;
      mem_write = 1'b0;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= S_FETCH;
      halt <= 1'b0;
      fault_code <= FAULT_NONE;
      instret <= '0;
    end else begin
      state <= state_n;
      halt <= halt || state_n == S_HALT;
      fault_code <= fault_n;
      instret <= instret + CNT_W'(retire);
    end
endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb_cpu_ctrl_fsm: directed instruction sequences with hand-computed strobe and counter expectations
module tb_cpu_ctrl_fsm;
  logic clk = 1'b0, rst = 1'b1;
  logic [31:0] inst = '0;
  logic imem_ready = 1'b0, dmem_ready = 1'b0, branch_taken = 1'b0;
  logic imem_req, ir_write, pc_write, reg_write, mem_read, mem_write, halt;
  logic [1:0] pc_src, wb_sel, fault_code;
  logic [31:0] instret;
  int checks = 0, errors = 0;

  cpu_ctrl_fsm #(.MEM_TIMEOUT(16), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .inst(inst), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .branch_taken(branch_taken), .imem_req(imem_req), .ir_write(ir_write), .pc_write(pc_write),
    .pc_src(pc_src), .reg_write(reg_write), .wb_sel(wb_sel), .mem_read(mem_read),
    .mem_write(mem_write), .halt(halt), .fault_code(fault_code), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] i);
    inst = i;
    imem_ready = 1'b1;
    #1 chk("ir_write", 32'(ir_write), 1);
    cyc();
    imem_ready = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    cyc();
    chk("rst_imem_req", 32'(imem_req), 0);
    rst = 1'b0;
    #1;
    chk("reset_imem_req", 32'(imem_req), 1);
    chk("reset_halt", 32'(halt), 0);
    chk("reset_fault", 32'(fault_code), 0);
    chk("reset_instret", instret, 0);
    fetch(32'h002081B3);
    chk("add_dec_req", 32'(imem_req), 0);
    chk("add_dec_rw", 32'(reg_write), 0);
    cyc();
    chk("add_exec_pcw", 32'(pc_write), 0);
    chk("add_exec_rw", 32'(reg_write), 0);
    cyc();
    chk("add_wb_rw", 32'(reg_write), 1);
    chk("add_wb_sel", 32'(wb_sel), 0);
    chk("add_wb_pcw", 32'(pc_write), 1);
    chk("add_wb_pcsrc", 32'(pc_src), 0);
    cyc();
    chk("add_fetch_rw", 32'(reg_write), 0);
    chk("add_instret", instret, 1);
    fetch(32'h00208463);
    cyc();
    branch_taken = 1'b1;
    #1 chk("beq_t_pcw", 32'(pc_write), 1);
    chk("beq_t_pcsrc", 32'(pc_src), 1);
    chk("beq_t_rw", 32'(reg_write), 0);
    cyc();
    chk("beq_t_req", 32'(imem_req), 1);
    chk("beq_t_instret", instret, 2);
    fetch(32'h00208463);
    cyc();
    branch_taken = 1'b0;
    #1 chk("beq_nt_pcw", 32'(pc_write), 1);
    chk("beq_nt_pcsrc", 32'(pc_src), 0);
    cyc();
    chk("beq_nt_instret", instret, 3);
    fetch(32'h0000A183);
    cyc();
    chk("lw_exec_rd", 32'(mem_read), 0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("lw_mem_rd", 32'(mem_read), 1);
      cyc();
    end
    dmem_ready = 1'b1;
    #1 chk("lw_rdy_rd", 32'(mem_read), 1);
    chk("lw_rdy_rw", 32'(reg_write), 0);
    chk("lw_rdy_pcw", 32'(pc_write), 0);
    cyc();
    dmem_ready = 1'b0;
    #1 chk("lw_wb_rw", 32'(reg_write), 1);
    chk("lw_wb_sel", 32'(wb_sel), 1);
    chk("lw_wb_rd", 32'(mem_read), 0);
    cyc();
    chk("lw_instret", instret, 4);
    fetch(32'h008000EF);
    cyc();
    cyc();
    chk("jal_wb_sel", 32'(wb_sel), 2);
    chk("jal_pcsrc", 32'(pc_src), 1);
    cyc();
    chk("jal_instret", instret, 5);
    fetch(32'h0030A023);
    cyc();
    cyc();
    repeat (15) cyc();
    dmem_ready = 1'b1;
    #1 chk("sw_late_wr", 32'(mem_write), 1);
    chk("sw_late_pcw", 32'(pc_write), 1);
    chk("sw_late_pcsrc", 32'(pc_src), 0);
    cyc();
    dmem_ready = 1'b0;
    #1 chk("sw_late_halt", 32'(halt), 0);
    chk("sw_late_req", 32'(imem_req), 1);
    chk("sw_late_instret", instret, 6);
    fetch(32'h0030A023);
    cyc();
    cyc();
    for (int i = 0; i < 16; i++) begin
      chk("sw_wait_wr", 32'(mem_write), 1);
      chk("sw_wait_halt", 32'(halt), 0);
      cyc();
    end
    chk("sw_to_wr", 32'(mem_write), 0);
    chk("sw_to_halt", 32'(halt), 1);
    chk("sw_to_fault", 32'(fault_code), 2);
    chk("sw_to_instret", instret, 6);
    do_reset();
    chk("rst2_halt", 32'(halt), 0);
    chk("rst2_fault", 32'(fault_code), 0);
    chk("rst2_instret", instret, 0);
    fetch(32'h00000073);
    chk("ecall_dec_halt", 32'(halt), 0);
    cyc();
    chk("ecall_halt", 32'(halt), 1);
    chk("ecall_fault", 32'(fault_code), 3);
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    inst = 32'h0000007F;
    repeat (100) cyc();
    chk("ecall_sticky_halt", 32'(halt), 1);
    chk("ecall_sticky_fault", 32'(fault_code), 3);
    chk("ecall_sticky_req", 32'(imem_req), 0);
    chk("ecall_sticky_irw", 32'(ir_write), 0);
    chk("ecall_instret", instret, 0);
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    do_reset();
    fetch(32'h0000007F);
    cyc();
    chk("ill_fault", 32'(fault_code), 1);
    inst = 32'h00000073;
    repeat (100) cyc();
    chk("ill_sticky_halt", 32'(halt), 1);
    chk("ill_sticky_fault", 32'(fault_code), 1);
    do_reset();
    fetch(32'h002081B3);
    cyc();
    cyc();
    cyc();
    chk("pre_abort_instret", instret, 1);
    fetch(32'h0000A183);
    cyc();
    cyc();
    chk("abort_mem_rd", 32'(mem_read), 1);
    rst = 1'b1;
    #1 chk("abort_rst_rd", 32'(mem_read), 0);
    cyc();
    rst = 1'b0;
    #1 chk("abort_req", 32'(imem_req), 1);
    chk("abort_rw", 32'(reg_write), 0);
    chk("abort_instret", instret, 0);
    chk("abort_halt", 32'(halt), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
